// File: rtl/spif_target_if.sv
// SPI flash pins plus byte-wide backing-memory port of the spif_target responder.
// slave = the flash target side, master = the MCU/bench side.
interface spif_target_if #(parameter int ADDR_BITS = 16) ();
  logic                 sclk;
  logic                 cs_n;
  logic [3:0]           si;
  logic [3:0]           so;
  logic [3:0]           so_oe;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd;
  logic [7:0]           mem_dout;
  logic                 mem_wr;
  logic [7:0]           mem_din;

  modport slave (
    input  sclk, cs_n, si, mem_dout,
    output so, so_oe, mem_addr, mem_rd, mem_wr, mem_din
  );

  modport master (
    output sclk, cs_n, si, mem_dout,
    input  so, so_oe, mem_addr, mem_rd, mem_wr, mem_din
  );
endinterface

// File: rtl/spif_target.sv
// SPI NOR flash responder (mode 0) serving a byte RAM; sclk/cs_n are edge-detected in the clk domain.
// Define SPIF_TARGET_QUAD_EN to add command 0x6B (quad output fast read).
module spif_target #(
  parameter int          ADDR_BITS = 16,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic         clk,
  input  logic         reset,
  spif_target_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_STATUS, S_ID, S_WRCMD, S_PROG, S_IGNORE
  } state_e;

  state_e               state_q, state_d;
  logic                 sclk_q, csn_q;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [7:0]           shin_q, shin_d;
  logic [7:0]           buf_q, buf_d;
  logic [7:0]           shout_q, shout_d;
  logic [2:0]           obit_q, obit_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [7:0]           cmd_q, cmd_d;
  logic                 quad_q, quad_d;
  logic                 wel_q, wel_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_rd_q, mem_rd_d, rd_pend_q;
  logic                 mem_wr_q, mem_wr_d;
  logic [7:0]           mem_din_q, mem_din_d;
  logic [3:0]           so_q, so_d, so_oe_q, so_oe_d;

  logic       rise, fall, cs_fall, byte_done, prefetch;
  logic [7:0] byte_in;
  logic       unused_si;

  assign rise      = bus.sclk & ~sclk_q;
  assign fall      = ~bus.sclk & sclk_q;
  assign cs_fall   = ~bus.cs_n & csn_q;
  assign byte_in   = {shin_q[6:0], bus.si[0]};
  assign byte_done = rise && (bitcnt_q == 3'd7);
  assign unused_si = ^bus.si[3:1];

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shin_d     = shin_q;
    buf_d      = buf_q;
    shout_d    = shout_q;
    obit_d     = obit_q;
    bcnt_d     = bcnt_q;
    cmd_d      = cmd_q;
    quad_d     = quad_q;
    wel_d      = wel_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_din_d  = mem_din_q;
    so_d       = so_q;
    so_oe_d    = so_oe_q;
    prefetch   = 1'b0;

    // read data lands one clk after the strobe; it is always the next byte to send
    if (rd_pend_q) buf_d = bus.mem_dout;

    if (bus.cs_n) begin
      state_d  = S_IDLE;
      bitcnt_d = '0;
      so_d     = '0;
      so_oe_d  = '0;
      if (state_q == S_WRCMD) wel_d = (cmd_q == 8'h06);
      if (cmd_q == 8'h02 && (state_q == S_ADDR || state_q == S_PROG)) wel_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (cs_fall) begin
        state_d  = S_CMD;
        bitcnt_d = '0;
      end
    end else begin
      if (rise) begin
        shin_d   = byte_in;
        bitcnt_d = bitcnt_q + 3'd1;
      end

      if (byte_done) begin
        case (state_q)
          S_CMD: begin
            cmd_d  = byte_in;
            quad_d = 1'b0;
            addr_d = '0;
            bcnt_d = '0;
            obit_d = '0;
            case (byte_in)
              8'h03, 8'h0B: state_d = S_ADDR;
              8'h05: begin
                state_d = S_STATUS;
                buf_d   = {6'b0, wel_q, 1'b0};
              end
              8'h9F: begin
                state_d = S_ID;
                buf_d   = JEDEC_ID[23:16];
              end
              8'h06, 8'h04: state_d = S_WRCMD;
              8'h02: state_d = wel_q ? S_ADDR : S_IGNORE;
`ifdef SPIF_TARGET_QUAD_EN
              8'h6B: begin
                state_d = S_ADDR;
                quad_d  = 1'b1;
              end
`endif
              default: state_d = S_IGNORE;
            endcase
          end
          S_ADDR: begin
            addr_d = ADDR_BITS'({addr_q, byte_in});
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd2) begin
              if (cmd_q == 8'h02) begin
                state_d = S_PROG;
              end else begin
                state_d    = (cmd_q == 8'h03) ? S_READ : S_DUMMY;
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_d;
              end
            end
          end
          S_DUMMY: state_d = S_READ;
          S_PROG: begin
            mem_wr_d       = 1'b1;
            mem_din_d      = byte_in;
            mem_addr_d     = addr_q;
            addr_d[7:0]    = addr_q[7:0] + 8'd1;
          end
          default: ;
        endcase
      end

      // 0x06/0x04 only count when exactly eight bits were clocked
      if (rise && state_q == S_WRCMD) state_d = S_IGNORE;

      if (fall && (state_q == S_READ || state_q == S_STATUS || state_q == S_ID)) begin
        if (quad_q) begin
          so_oe_d = 4'b1111;
          if (!obit_q[0]) begin
            so_d     = buf_q[7:4];
            shout_d  = buf_q;
            prefetch = 1'b1;
          end else begin
            so_d = shout_q[3:0];
          end
          obit_d = obit_q ^ 3'd1;
        end else begin
          so_oe_d = 4'b0010;
          if (obit_q == 3'd0) begin
            so_d    = {2'b00, buf_q[7], 1'b0};
            shout_d = {buf_q[6:0], 1'b0};
            if (state_q == S_READ) prefetch = 1'b1;
            if (state_q == S_ID) begin
              case (bcnt_q)
                2'd0:    buf_d = JEDEC_ID[15:8];
                2'd1:    buf_d = JEDEC_ID[7:0];
                default: buf_d = 8'hFF;
              endcase
              if (bcnt_q != 2'd3) bcnt_d = bcnt_q + 2'd1;
            end
          end else begin
            so_d    = {2'b00, shout_q[7], 1'b0};
            shout_d = {shout_q[6:0], 1'b0};
          end
          obit_d = obit_q + 3'd1;
        end
      end

      if (prefetch) begin
        addr_d     = addr_q + ADDR_BITS'(1);
        mem_addr_d = addr_q + ADDR_BITS'(1);
        mem_rd_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // pin samples are not reset so a transaction in flight is never mistaken for a new cs_n fall
    sclk_q <= bus.sclk;
    csn_q  <= bus.cs_n;
    if (reset) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shin_q     <= '0;
      buf_q      <= '0;
      shout_q    <= '0;
      obit_q     <= '0;
      bcnt_q     <= '0;
      cmd_q      <= '0;
      quad_q     <= 1'b0;
      wel_q      <= 1'b0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_din_q  <= '0;
      so_q       <= '0;
      so_oe_q    <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shin_q     <= shin_d;
      buf_q      <= buf_d;
      shout_q    <= shout_d;
      obit_q     <= obit_d;
      bcnt_q     <= bcnt_d;
      cmd_q      <= cmd_d;
      quad_q     <= quad_d;
      wel_q      <= wel_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      rd_pend_q  <= mem_rd_q;
      mem_wr_q   <= mem_wr_d;
      mem_din_q  <= mem_din_d;
      so_q       <= so_d;
      so_oe_q    <= so_oe_d;
    end
  end

  assign bus.so       = so_q;
  assign bus.so_oe    = so_oe_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_din  = mem_din_q;

endmodule

// File: tb/tb_spif_target.sv
// Bench for spif_target: SPI initiator tasks push expected bytes/writes; a monitor pops and compares.
module tb_spif_target;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spif_target_if #(.ADDR_BITS(16)) bus ();

  spif_target #(.ADDR_BITS(16), .JEDEC_ID(24'hEF4016)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

`ifdef SPIF_TARGET_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif

  // backing RAM with a bench-side preload port
  logic [7:0]  ram [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_din;
    if (rst) bus.mem_dout <= 8'h00;
    else if (bus.mem_rd) bus.mem_dout <= ram[bus.mem_addr];
  end

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic [23:0] wr_q  [$];
  logic [3:0]  exp_oe = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: samples 1 time unit after each posedge
  logic        sclk_p = 1'b0;
  int          nb     = 0;
  logic [7:0]  rx     = 8'h00;
  logic [7:0]  eb;
  logic [23:0] ew;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.cs_n) begin
        nb = 0;
      end else if (bus.sclk && !sclk_p) begin
        chk("so_oe_at_rise", {28'h0, bus.so_oe}, {28'h0, exp_oe});
        if (exp_oe == 4'b0010) begin
          rx = {rx[6:0], bus.so[1]};
          nb += 1;
        end else if (exp_oe == 4'b1111) begin
          rx = {rx[3:0], bus.so};
          nb += 4;
        end
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_byte: got %0h expected none", rx);
          end else begin
            eb = exp_q.pop_front();
            chk("rx_byte", {24'h0, rx}, {24'h0, eb});
          end
        end
      end
      sclk_p = bus.sclk;
      if (bus.mem_wr) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_wr: got %0h@%0h expected none", bus.mem_din, bus.mem_addr);
        end else begin
          ew = wr_q.pop_front();
          chk("mem_wr", {8'h0, bus.mem_addr, bus.mem_din}, {8'h0, ew});
        end
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // one SPI bit: sclk low 4 clk, high 4 clk
  task automatic sbit(input logic b);
    @(negedge clk);
    bus.si = {3'b000, b};
    repeat (3) @(negedge clk);
    bus.sclk = 1'b1;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    exp_oe = 4'b0000;
    for (int i = 7; i >= 0; i--) sbit(b[i]);
  endtask

  task automatic recv(input logic [7:0] e);
    exp_q.push_back(e);
    exp_oe = 4'b0010;
    for (int i = 0; i < 8; i++) sbit(1'b0);
  endtask

  task automatic qrecv(input logic [7:0] e);
    if (QUAD) begin
      exp_q.push_back(e);
      exp_oe = 4'b1111;
    end else begin
      exp_oe = 4'b0000;
    end
    sbit(1'b0);
    sbit(1'b0);
  endtask

  task automatic cs_on();
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_off();
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic rdsr(input logic [7:0] e);
    cs_on(); send(8'h05); recv(e); recv(e); cs_off();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.si = 4'h0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    poke(16'h0100, 8'h11); poke(16'h0101, 8'h22);
    poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
    poke(16'hFFFF, 8'h5A); poke(16'h0000, 8'h00);
    @(posedge clk); #1;
    chk("rst_so",       {28'h0, bus.so},    32'h0);
    chk("rst_so_oe",    {28'h0, bus.so_oe}, 32'h0);
    chk("rst_mem_rd",   {31'h0, bus.mem_rd}, 32'h0);
    chk("rst_mem_wr",   {31'h0, bus.mem_wr}, 32'h0);
    chk("rst_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
    chk("rst_mem_din",  {24'h0, bus.mem_din}, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    // plain read
    cs_on(); send(8'h03); send(8'h00); send(8'h01); send(8'h00);
    recv(8'h11); recv(8'h22); recv(8'h33); recv(8'h44); cs_off();

    // JEDEC ID then 0xFF fill
    cs_on(); send(8'h9F); recv(8'hEF); recv(8'h40); recv(8'h16); recv(8'hFF); cs_off();

    // program without WEL is ignored
    cs_on(); send(8'h02); send(8'h00); send(8'h00); send(8'h10); send(8'hAA); cs_off();
    rdsr(8'h00);

    // WREN, then program across the page end
    cs_on(); send(8'h06); cs_off();
    rdsr(8'h02);
    wr_q.push_back({16'h00FF, 8'hAA});
    wr_q.push_back({16'h0000, 8'hBB});
    cs_on(); send(8'h02); send(8'h00); send(8'h00); send(8'hFF); send(8'hAA); send(8'hBB); cs_off();
    rdsr(8'h00);

    // read back the programmed byte and continue into 0x0100
    cs_on(); send(8'h03); send(8'h00); send(8'h00); send(8'hFF); recv(8'hAA); recv(8'h11); cs_off();

    // top-of-memory wrap; upper flash address byte is ignored
    cs_on(); send(8'h03); send(8'h12); send(8'hFF); send(8'hFF); recv(8'h5A); recv(8'hBB); cs_off();

    // fast read with 8 dummy clocks
    cs_on(); send(8'h0B); send(8'h00); send(8'h01); send(8'h01); send(8'h00);
    recv(8'h22); recv(8'h33); cs_off();

    // partial program byte is discarded and WEL still clears
    cs_on(); send(8'h06); cs_off();
    cs_on(); send(8'h02); send(8'h00); send(8'h00); send(8'h20);
    exp_oe = 4'b0000;
    for (int i = 0; i < 4; i++) sbit(1'b1);
    cs_off();
    rdsr(8'h00);

    // WREN followed by an extra bit does not set WEL
    cs_on(); send(8'h06); sbit(1'b0); cs_off();
    rdsr(8'h00);

    // reset in the middle of a read
    cs_on(); send(8'h06); cs_off();
    cs_on(); send(8'h03); send(8'h00); send(8'h01); send(8'h00);
    exp_oe = 4'b0010;
    for (int i = 0; i < 4; i++) sbit(1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midread_rst_so_oe", {28'h0, bus.so_oe}, 32'h0);
    @(negedge clk); bus.cs_n = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    rdsr(8'h00);

    // quad output fast read (so_oe stays 0 without the quad build)
    cs_on(); send(8'h6B); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
    qrecv(8'h11); qrecv(8'h22); qrecv(8'h33); cs_off();

    repeat (20) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'h0);
    chk("wr_q_drained",  wr_q.size(),  32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spif_target.md
Name: spif_target

Overview:
- Synthesizable SPI NOR flash responder: the target side of the flash link driven by the MCU's SPI flash controller.
- Lets an FPGA build or a simulation bench boot the MCU from on-chip byte RAM instead of an external flash chip.
- Decodes a subset of standard flash commands in SPI mode 0 and serves or stores bytes through a byte-wide memory port.
- Runs in the same clock domain as the MCU, so the SPI pins are edge-detected directly with no synchronizer.

Parameters:
- ADDR_BITS, 16: byte address width of the backing memory. Flash address bits above this are ignored.
- JEDEC_ID, 24'hEF4016: returned by command 0x9F, MSB first.

Ports:
- clk  in  1  system clock, shared with the MCU
- reset  in  1  synchronous reset, active-high
- sclk  in  1  SPI clock from the initiator
- cs_n  in  1  chip select, active low
- si  in  4  initiator data lines; si[0] is MOSI
- so  out  4  target data lines; so[1] is MISO in single mode
- so_oe  out  4  output enable per so bit
- mem_addr  out  ADDR_BITS  byte address to the backing RAM
- mem_rd  out  1  read strobe; mem_dout is valid exactly 1 clk later
- mem_dout  in  8  read data
- mem_wr  out  1  write strobe, 1 clk wide
- mem_din  out  8  write data

Behaviour:
- Reset values: so=0, so_oe=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_din=0, WEL=0, state IDLE.
- Edge detection: sclk_q is registered each clk. rise = sclk & ~sclk_q; fall = ~sclk & sclk_q.
- Timing requirement: sclk half-period ≥ 3 clk (initiator prescale ≥ 2). Faster sclk is unsupported.
- Framing:
  - cs_n high forces IDLE on the next clk, so_oe=0, and clears the bit counter, from any state.
  - A cs_n falling edge starts a transaction in CMD.
- Input sampling:
  - On rise, si[0] shifts into an 8-bit register, MSB first.
  - A 3-bit counter marks byte completion at its 8th rise.
- Output timing:
  - On fall, the next output bit is driven on so[1]; so_oe=4'b0010 while outputting.
  - The first data bit is driven on the fall immediately after the last command, address, or dummy bit.
- States:
  - IDLE: waits for cs_n low.
  - CMD → decodes the command byte:
    - 0x03 → ADDR (3 bytes) → READ.
    - 0x0B → ADDR → DUMMY (8 clocks) → READ.
    - 0x05 → STATUS. Byte is {6'b0, WEL, WIP=0}, repeated while clocked.
    - 0x9F → ID. Three bytes of JEDEC_ID, then 0xFF repeated.
    - 0x06: sets WEL. 0x04: clears WEL. Either takes effect only when cs_n rises after exactly 8 bits.
    - 0x02 → ADDR → PROG, only if WEL=1; otherwise IGNORE.
    - Any other code → IGNORE. IGNORE holds so_oe=0 until cs_n rises.
- READ:
  - mem_rd is pulsed the clk after the address completes. The returned byte loads the output shifter before the next fall.
  - A prefetch of addr+1 is issued on the clk after the fall that drives bit 7 of the current byte.
  - The address wraps from 2^ADDR_BITS−1 to 0.
- PROG:
  - Each completed input byte produces a 1-clk mem_wr with mem_din = that byte at the current address.
  - The address increments in bits [7:0] only, wrapping within the 256-byte page.
  - Partial bytes at cs_n rise are discarded.
  - WEL clears when cs_n rises after any 0x02 transaction.
- Write policy: direct overwrite. No erase and no AND semantics.
- Simultaneous events: a cs_n rise on the same clk as a byte completion cancels the mem_wr.
- Reset mid-transaction: returns to IDLE and clears WEL. Memory contents are untouched.

Optional Feature:
- Macro SPIF_TARGET_QUAD_EN enables command 0x6B (quad output fast read).
  - Sequence: command and 3 address bytes on si[0], then 8 dummy clocks, then data on so[3:0] with so_oe=4'b1111.
  - Each fall drives one nibble, high nibble first, 2 clocks per byte.
  - Address increments and wraps as in READ. Prefetch is issued on the clk after the high-nibble fall.
- Without the macro, 0x6B is treated as unknown → IGNORE.

Test Plan:
- RAM[0x0100..0x0103]=11 22 33 44; cs_n low, send 03 00 01 00, clock 32 bits → MISO returns 0x11223344; so_oe=0010 only during data.
- Send 9F, clock 32 bits → EF 40 16 FF.
- Send 02 00 00 10 AA with WEL=0 → no mem_wr; RDSR returns 0x00. Then 06 (cs_n cycle), 02 00 00 FF AA BB → writes AA@0x00FF, BB@0x0000 (page wrap); a following RDSR returns 0x00.
- Read at 0xFFFF with ADDR_BITS=16, 2 bytes → addresses 0xFFFF then 0x0000.
- Deassert cs_n after 4 bits of a program data byte → no mem_wr. Assert reset mid-READ → so_oe=0 next clk and WEL=0.
- With SPIF_TARGET_QUAD_EN: 6B 00 01 00 + 8 dummy clocks → so[3:0] nibbles 1,1,2,2,3,3 on successive falls. Without the macro → so_oe stays 0.
